// File: rtl/pf_pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, operand forwarding
// select codes and nPC source select codes.
package pf_pipeline_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StAnnul = 2'd2
    } hz_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    typedef logic [1:0] npc_sel_t;

    localparam npc_sel_t NPC_SEQ    = 2'b00;
    localparam npc_sel_t NPC_TARGET = 2'b01;

endpackage

// File: rtl/forward_select.sv
// Per-operand forwarding priority matcher: the youngest writing stage (EX, then
// MEM, then WB) whose destination equals the operand supplies the value.
module forward_select
    import pf_pipeline_pkg::*;
#(
    parameter int unsigned REG_W = pf_pipeline_pkg::REG_W
) (
    input  logic             i_enable,
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_en,
    input  logic             i_ex_load,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_en,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_wb_en,
    output fwd_sel_t         o_sel
);

    logic w_src_nz;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nz  = (i_src != '0);
    // A load in EX has no result yet; the stall logic covers that case.
    assign w_ex_hit  = i_ex_en && !i_ex_load && (i_ex_rd == i_src);
    assign w_mem_hit = i_mem_en && (i_mem_rd == i_src);
    assign w_wb_hit  = i_wb_en && (i_wb_rd == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (i_enable && w_src_nz) begin
            if (w_ex_hit) begin
                o_sel = FWD_EX;
            end else if (w_mem_hit) begin
                o_sel = FWD_MEM;
            end else if (w_wb_hit) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// ID-stage hazard, annul and forwarding control. Optional statistics counters
// are enabled with the HAZARD_STATS_EN macro.
module hazard_forwarding_unit
    import pf_pipeline_pkg::*;
#(
    parameter int unsigned REG_W = pf_pipeline_pkg::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic [REG_W-1:0] ID_rd,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_store,
    input  logic             ID_B_instr,
    input  logic             ID_Call_instr,
    input  logic             ID_29_a,
    input  logic             branch_taken,
    input  logic             branch_always,
    input  logic [REG_W-1:0] EX_rd,
    input  logic [REG_W-1:0] MEM_rd,
    input  logic [REG_W-1:0] WB_rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    output logic             S,
    output logic             PC_LE,
    output logic             nPC_LE,
    output logic             IFID_LE,
    output logic [1:0]       npc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_pd,
    output logic [1:0]       hz_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] annul_count
`endif
);

    hz_state_e r_state;
    hz_state_e w_state_next;
    logic      w_load_use;
    logic      w_redirect;
    logic      w_annul_slot;
    logic      w_fwd_en;

    assign w_load_use = EX_load_instr && EX_RF_enable && (EX_rd != '0) &&
                        ((ID_use_rs1 && (EX_rd == ID_rs1)) ||
                         (ID_use_rs2 && (EX_rd == ID_rs2)) ||
                         (ID_store   && (EX_rd == ID_rd)));

    assign w_redirect   = ID_Call_instr || (ID_B_instr && branch_taken);
    assign w_annul_slot = ID_B_instr && ID_29_a && (!branch_taken || branch_always);

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StRun;
        S            = 1'b0;
        PC_LE        = 1'b1;
        nPC_LE       = 1'b1;
        IFID_LE      = 1'b1;
        npc_sel      = NPC_SEQ;
        w_fwd_en     = 1'b1;
        case (r_state)
            StRun: begin
                if (w_load_use) begin
                    // Hold IF/ID so the branch, if any, is re-evaluated next cycle.
                    S            = 1'b1;
                    PC_LE        = 1'b0;
                    nPC_LE       = 1'b0;
                    IFID_LE      = 1'b0;
                    w_state_next = StStall;
                end else begin
                    if (w_redirect) begin
                        npc_sel = NPC_TARGET;
                    end
                    if (w_annul_slot) begin
                        w_state_next = StAnnul;
                    end
                end
            end
            StStall: begin
                if (w_redirect) begin
                    npc_sel = NPC_TARGET;
                end
                if (w_annul_slot) begin
                    w_state_next = StAnnul;
                end
            end
            StAnnul: begin
                S        = 1'b1;
                w_fwd_en = 1'b0;
            end
            default: begin
                S        = 1'b1;
                w_fwd_en = 1'b0;
            end
        endcase
        if (!R) begin
            S            = 1'b1;
            PC_LE        = 1'b1;
            nPC_LE       = 1'b1;
            IFID_LE      = 1'b1;
            npc_sel      = NPC_SEQ;
            w_fwd_en     = 1'b0;
            w_state_next = StRun;
        end
    end

    assign hz_state = r_state;

    forward_select #(
        .REG_W (REG_W)
    ) u_fwd_a (
        .i_enable  (w_fwd_en),
        .i_src     (ID_rs1),
        .i_ex_rd   (EX_rd),
        .i_ex_en   (EX_RF_enable),
        .i_ex_load (EX_load_instr),
        .i_mem_rd  (MEM_rd),
        .i_mem_en  (MEM_RF_enable),
        .i_wb_rd   (WB_rd),
        .i_wb_en   (WB_RF_enable),
        .o_sel     (fwd_a)
    );

    forward_select #(
        .REG_W (REG_W)
    ) u_fwd_b (
        .i_enable  (w_fwd_en),
        .i_src     (ID_rs2),
        .i_ex_rd   (EX_rd),
        .i_ex_en   (EX_RF_enable),
        .i_ex_load (EX_load_instr),
        .i_mem_rd  (MEM_rd),
        .i_mem_en  (MEM_RF_enable),
        .i_wb_rd   (WB_rd),
        .i_wb_en   (WB_RF_enable),
        .o_sel     (fwd_b)
    );

    forward_select #(
        .REG_W (REG_W)
    ) u_fwd_pd (
        .i_enable  (w_fwd_en),
        .i_src     (ID_rd),
        .i_ex_rd   (EX_rd),
        .i_ex_en   (EX_RF_enable),
        .i_ex_load (EX_load_instr),
        .i_mem_rd  (MEM_rd),
        .i_mem_en  (MEM_RF_enable),
        .i_wb_rd   (WB_rd),
        .i_wb_en   (WB_RF_enable),
        .o_sel     (fwd_pd)
    );

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_annul_cnt;
    logic             w_stall_entry;
    logic             w_annul_entry;

    assign w_stall_entry = (w_state_next == StStall) && (r_state != StStall);
    assign w_annul_entry = (w_state_next == StAnnul) && (r_state != StAnnul);

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_stall_cnt <= '0;
            r_annul_cnt <= '0;
        end else begin
            if (w_stall_entry && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_annul_entry && (r_annul_cnt != '1)) begin
                r_annul_cnt <= r_annul_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign annul_count = r_annul_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Table-driven scoreboard bench for hazard_forwarding_unit; count checks are
// compiled in when HAZARD_STATS_EN is defined.
module tb_hazard_forwarding_unit;

    logic       Clk;
    logic       R;
    logic [4:0] ID_rs1, ID_rs2, ID_rd;
    logic       ID_use_rs1, ID_use_rs2, ID_store;
    logic       ID_B_instr, ID_Call_instr, ID_29_a;
    logic       branch_taken, branch_always;
    logic [4:0] EX_rd, MEM_rd, WB_rd;
    logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr;
    logic       S, PC_LE, nPC_LE, IFID_LE;
    logic [1:0] npc_sel, fwd_a, fwd_b, fwd_pd, hz_state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, annul_count;
`endif

    hazard_forwarding_unit #(
        .REG_W (5),
        .CNT_W (16)
    ) dut (
        .Clk           (Clk),
        .R             (R),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_rd         (ID_rd),
        .ID_use_rs1    (ID_use_rs1),
        .ID_use_rs2    (ID_use_rs2),
        .ID_store      (ID_store),
        .ID_B_instr    (ID_B_instr),
        .ID_Call_instr (ID_Call_instr),
        .ID_29_a       (ID_29_a),
        .branch_taken  (branch_taken),
        .branch_always (branch_always),
        .EX_rd         (EX_rd),
        .MEM_rd        (MEM_rd),
        .WB_rd         (WB_rd),
        .EX_RF_enable  (EX_RF_enable),
        .MEM_RF_enable (MEM_RF_enable),
        .WB_RF_enable  (WB_RF_enable),
        .EX_load_instr (EX_load_instr),
        .S             (S),
        .PC_LE         (PC_LE),
        .nPC_LE        (nPC_LE),
        .IFID_LE       (IFID_LE),
        .npc_sel       (npc_sel),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .fwd_pd        (fwd_pd),
        .hz_state      (hz_state)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count   (stall_count),
        .annul_count   (annul_count)
`endif
    );

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use1;
        logic       use2;
        logic       store;
        logic       b;
        logic       call;
        logic       a;
        logic       taken;
        logic       bal;
        logic [4:0] ex_rd;
        logic [4:0] mem_rd;
        logic [4:0] wb_rd;
        logic       ex_en;
        logic       mem_en;
        logic       wb_en;
        logic       ex_load;
    } in_t;

    typedef struct packed {
        logic       s;
        logic       pc;
        logic       npc;
        logic       ifid;
        logic [1:0] np;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] fpd;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    vec_t        vecs[$];
    exp_t        sb_q[$];
    string       nm_q[$];
    int          checks;
    int          errors;
    logic [15:0] m_stall;
    logic [15:0] m_annul;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic exp_t mk(logic s, logic le, logic [1:0] np, logic [1:0] fa,
                                logic [1:0] fb, logic [1:0] fpd, logic [1:0] st);
        exp_t e;
        e.s    = s;
        e.pc   = le;
        e.npc  = le;
        e.ifid = le;
        e.np   = np;
        e.fa   = fa;
        e.fb   = fb;
        e.fpd  = fpd;
        e.st   = st;
        return e;
    endfunction

    task automatic add(string n, in_t v, exp_t e);
        vec_t t;
        t.name = n;
        t.i    = v;
        t.e    = e;
        vecs.push_back(t);
    endtask

    task automatic drive(in_t v);
        ID_rs1        = v.rs1;
        ID_rs2        = v.rs2;
        ID_rd         = v.rd;
        ID_use_rs1    = v.use1;
        ID_use_rs2    = v.use2;
        ID_store      = v.store;
        ID_B_instr    = v.b;
        ID_Call_instr = v.call;
        ID_29_a       = v.a;
        branch_taken  = v.taken;
        branch_always = v.bal;
        EX_rd         = v.ex_rd;
        MEM_rd        = v.mem_rd;
        WB_rd         = v.wb_rd;
        EX_RF_enable  = v.ex_en;
        MEM_RF_enable = v.mem_en;
        WB_RF_enable  = v.wb_en;
        EX_load_instr = v.ex_load;
    endtask

    // Expected record is queued at drive time and retired once outputs settle.
    task automatic expect_out(exp_t e, string n);
        exp_t  ee;
        exp_t  act;
        string nn;
        sb_q.push_back(e);
        nm_q.push_back(n);
        #1;
        ee  = sb_q.pop_front();
        nn  = nm_q.pop_front();
        act = {S, PC_LE, nPC_LE, IFID_LE, npc_sel, fwd_a, fwd_b, fwd_pd, hz_state};
        checks++;
        if (act !== ee) begin
            errors++;
            $display("FAIL %s: got {S,PC,nPC,IFID,npc,fa,fb,fpd,st}=%b required %b",
                     nn, act, ee);
        end
    endtask

    task automatic check_counts(string n);
`ifdef HAZARD_STATS_EN
        checks++;
        if ((stall_count !== m_stall) || (annul_count !== m_annul)) begin
            errors++;
            $display("FAIL %s_counts: got stall %0d annul %0d required stall %0d annul %0d",
                     n, stall_count, annul_count, m_stall, m_annul);
        end
`else
        if (n.len() == 0) $display("empty check name");
`endif
    endtask

    initial begin
        in_t        v;
        logic [1:0] prev_st;
        checks  = 0;
        errors  = 0;
        m_stall = '0;
        m_annul = '0;

        v = '0;
        add("idle", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.rs1 = 5; v.ex_rd = 5; v.mem_rd = 5; v.ex_en = 1; v.mem_en = 1;
        add("fwd_ex_over_mem", v, mk(1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0));
        v.ex_en = 0;
        add("fwd_mem_ex_off", v, mk(1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0));
        v = '0; v.rs2 = 0; v.wb_rd = 0; v.wb_en = 1;
        add("fwd_r0_never", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.rs1 = 9; v.ex_rd = 9; v.ex_en = 1; v.rs2 = 7; v.wb_rd = 7; v.wb_en = 1;
        v.rd = 12; v.mem_rd = 12; v.mem_en = 1;
        add("fwd_three_stages", v, mk(1'b0, 1'b1, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0));
        v = '0; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 4; v.rs1 = 4; v.mem_rd = 4; v.mem_en = 1;
        add("fwd_skip_ex_load", v, mk(1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0));
        v = '0; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 3; v.rs2 = 3; v.use2 = 1;
        add("load_use_rs2", v, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0;
        add("stall_cycle", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1));
        add("run_after_stall", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.b = 1; v.a = 1;
        add("annul_not_taken", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 5; v.rs1 = 5; v.use1 = 1;
        add("annul_cycle", v, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2));
        v = '0;
        add("run_after_annul", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.b = 1; v.a = 1; v.taken = 1; v.bal = 1;
        add("ba_a", v, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0;
        add("ba_a_annul", v, mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2));
        add("run_after_ba", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.b = 1; v.taken = 1;
        add("be_taken", v, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0;
        add("be_no_annul", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 8; v.rs1 = 8; v.use1 = 1;
        v.b = 1; v.taken = 1;
        add("lu_with_branch", v, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.b = 1; v.taken = 1;
        add("branch_in_stall", v, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1));
        v = '0;
        add("run_after_branch", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.call = 1;
        add("call", v, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0;
        add("run_after_call", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.b = 1; v.a = 1; v.taken = 1;
        add("bne_a_taken", v, mk(1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0;
        add("bne_a_no_annul", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0; v.store = 1; v.rd = 6; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 6;
        add("load_use_store", v, mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        v = '0;
        add("stall_store", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1));
        add("run_final", v, mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));

        // Reset held with hazard, branch and forwarding inputs all active.
        R = 1'b0;
        v = '0; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 3; v.rs2 = 3; v.use2 = 1;
        v.b = 1; v.taken = 1; v.call = 1; v.rs1 = 3; v.mem_rd = 3; v.mem_en = 1;
        drive(v);
        #3;
        expect_out(mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "reset_hold");
        check_counts("reset_hold");
        repeat (2) @(posedge Clk);
        expect_out(mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "reset_clocked");
        @(negedge Clk);
        drive('0);
        R = 1'b1;

        prev_st = 2'd0;
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge Clk);
            drive(vecs[k].i);
            if ((vecs[k].e.st == 2'd1) && (prev_st != 2'd1)) m_stall = m_stall + 16'd1;
            if ((vecs[k].e.st == 2'd2) && (prev_st != 2'd2)) m_annul = m_annul + 16'd1;
            prev_st = vecs[k].e.st;
            expect_out(vecs[k].e, vecs[k].name);
            check_counts(vecs[k].name);
        end

        // Reset asserted in the middle of ANNUL.
        @(negedge Clk);
        v = '0; v.b = 1; v.a = 1;
        drive(v);
        expect_out(mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqa_branch");
        @(negedge Clk);
        v = '0; v.rs1 = 5; v.ex_rd = 5; v.ex_en = 1;
        drive(v);
        m_annul = m_annul + 16'd1;
        expect_out(mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2), "seqa_annul");
        check_counts("seqa_annul");
        #1;
        R = 1'b0;
        m_stall = '0;
        m_annul = '0;
        expect_out(mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqa_reset_in_annul");
        check_counts("seqa_reset_in_annul");
        @(negedge Clk);
        drive('0);
        R = 1'b1;
        expect_out(mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqa_released");
        @(negedge Clk);
        expect_out(mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqa_run");

        // Reset pulsed during STALL while a would-annul branch waits in ID.
        @(negedge Clk);
        v = '0; v.ex_load = 1; v.ex_en = 1; v.ex_rd = 4; v.rs1 = 4; v.use1 = 1;
        drive(v);
        expect_out(mk(1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqb_load_use");
        @(negedge Clk);
        v = '0; v.b = 1; v.a = 1;
        drive(v);
        m_stall = m_stall + 16'd1;
        expect_out(mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1), "seqb_stall");
        check_counts("seqb_stall");
        #1;
        R = 1'b0;
        m_stall = '0;
        m_annul = '0;
        expect_out(mk(1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqb_reset_in_stall");
        @(negedge Clk);
        drive('0);
        R = 1'b1;
        expect_out(mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqb_released");
        @(negedge Clk);
        expect_out(mk(1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), "seqb_no_annul");
        check_counts("seqb_no_annul");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
